// File: rtl/weighted_window_accum.sv
// Weighted-window accumulator: sums data*weight and weight over a window, launches one
// divide per window and presents the weighted mean downstream with valid/ready.
module weighted_window_accum #(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [15:0]      in_weight,
   input  logic             flush,
   output logic             div_start,
   output logic [63:0]      div_num,
   output logic [31:0]      div_den,
   input  logic             div_done,
   input  logic [31:0]      div_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_mean,
   output logic             out_err,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_OUTPUT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
      logic [64:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum[63:0];
   endfunction

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   state_t           state_r, next_state_s;
   logic [63:0]      acc_num_r, num_next_s;
   logic [31:0]      acc_den_r, den_next_s;
   logic [CNT_W-1:0] cnt_r, cnt_next_s;
   logic [47:0]      prod_s;
   logic             accept_s, close_s, take_done_s;
   logic             in_ready_r, div_start_r, out_valid_r, out_err_r, wait_armed_r;
   logic [63:0]      div_num_r;
   logic [31:0]      div_den_r, out_mean_r;
   logic [CNT_W-1:0] out_count_r;

   // Next-state decode, sample accept and window-close detection
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      close_s      = 1'b0;
      take_done_s  = 1'b0;
      prod_s       = {16'h0000, in_data} * {32'h0000_0000, in_weight};
      num_next_s   = acc_num_r;
      den_next_s   = acc_den_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         ST_ACCUM: begin
            accept_s = in_valid & in_ready_r;
            if (accept_s) begin
               num_next_s = sat_add64(acc_num_r, {16'h0000, prod_s});
               den_next_s = sat_add32(acc_den_r, {16'h0000, in_weight});
               cnt_next_s = cnt_r + CNT_ONE;
            end else begin
               cnt_next_s = cnt_r;
            end
            // a flush on an empty window is ignored; a flush with an accept includes the sample
            close_s = (accept_s && (cnt_next_s == WINDOW_C)) || (flush && (cnt_next_s != CNT_ZERO));
            if (close_s) begin
               next_state_s = (den_next_s == 32'h0000_0000) ? ST_OUTPUT : ST_LAUNCH;
            end else begin
               next_state_s = ST_ACCUM;
            end
         end
         ST_LAUNCH: next_state_s = ST_WAIT;
         ST_WAIT: begin
            // the first WAIT cycle still sees the previous operation's done level
            take_done_s = wait_armed_r & div_done;
            if (take_done_s) begin
               next_state_s = ST_OUTPUT;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_OUTPUT: begin
            if (out_ready) begin
               next_state_s = ST_ACCUM;
            end else begin
               next_state_s = ST_OUTPUT;
            end
         end
         default: next_state_s = ST_ACCUM;
      endcase
   end

   // State register, accumulators and registered outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r      <= ST_ACCUM;
         acc_num_r    <= 64'h0;
         acc_den_r    <= 32'h0;
         cnt_r        <= CNT_ZERO;
         in_ready_r   <= 1'b0;
         div_start_r  <= 1'b0;
         out_valid_r  <= 1'b0;
         out_err_r    <= 1'b0;
         wait_armed_r <= 1'b0;
         div_num_r    <= 64'h0;
         div_den_r    <= 32'h0;
         out_mean_r   <= 32'h0;
         out_count_r  <= CNT_ZERO;
      end else begin
         state_r      <= next_state_s;
         in_ready_r   <= (next_state_s == ST_ACCUM);
         div_start_r  <= (next_state_s == ST_LAUNCH);
         out_valid_r  <= (next_state_s == ST_OUTPUT);
         wait_armed_r <= (state_r == ST_WAIT);
         if (close_s) begin
            div_num_r   <= num_next_s;
            div_den_r   <= den_next_s;
            out_count_r <= cnt_next_s;
            acc_num_r   <= 64'h0;
            acc_den_r   <= 32'h0;
            cnt_r       <= CNT_ZERO;
            if (den_next_s == 32'h0000_0000) begin
               out_mean_r <= 32'h0;
               out_err_r  <= 1'b1;
            end
         end else begin
            acc_num_r <= num_next_s;
            acc_den_r <= den_next_s;
            cnt_r     <= cnt_next_s;
         end
         if (take_done_s) begin
            out_mean_r <= div_result;
            out_err_r  <= 1'b0;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign div_start = div_start_r;
   assign div_num   = div_num_r;
   assign div_den   = div_den_r;
   assign out_valid = out_valid_r;
   assign out_mean  = out_mean_r;
   assign out_err   = out_err_r;
   assign out_count = out_count_r;

endmodule

// File: tb/tb_weighted_window_accum.sv
// Randomized bench for weighted_window_accum: a per-window sample list is reduced with plain
// arithmetic to the expected numerator/denominator, and a 4-cycle divider model answers starts.
module tb_weighted_window_accum;

   localparam int WINDOW = 4;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic [15:0]      in_weight;
   logic             flush;
   logic             div_start;
   logic [63:0]      div_num;
   logic [31:0]      div_den;
   logic             div_done;
   logic [31:0]      div_result;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_mean;
   logic             out_err;
   logic [CNT_W-1:0] out_count;

   always #5 clk = ~clk;

   weighted_window_accum #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
      .flush(flush),
      .div_start(div_start), .div_num(div_num), .div_den(div_den),
      .div_done(div_done), .div_result(div_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_mean(out_mean),
      .out_err(out_err), .out_count(out_count)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int start_cnt    = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Divider: done is a level that stays high until the cycle after the next start
   int          dv_timer = 0;
   logic [31:0] dv_pend;
   logic [31:0] dv_quot = 32'h0;
   always @(negedge clk) begin
      if (div_start === 1'b1) begin
         dv_timer = 4;
         dv_pend  = $urandom;
         if (dv_pend == dv_quot) dv_pend = dv_pend ^ 32'h1;
      end else if (dv_timer > 0) begin
         div_done = 1'b0;
         dv_timer--;
         if (dv_timer == 0) begin
            div_done   = 1'b1;
            div_result = dv_pend;
            dv_quot    = dv_pend;
         end
      end
   end

   always @(posedge clk) if (div_start === 1'b1) start_cnt++;

   // Reference model: samples of the open window, reduced when it closes
   logic [31:0] q_d[$];
   logic [15:0] q_w[$];
   logic [63:0] exp_num;
   logic [31:0] exp_den;
   logic [15:0] exp_cnt;
   logic        exp_err;

   function automatic void close_model();
      logic [127:0] n;
      logic [63:0]  d;
      n = 128'h0;
      d = 64'h0;
      foreach (q_d[i]) begin
         n = n + 128'(q_d[i]) * 128'(q_w[i]);
         d = d + 64'(q_w[i]);
      end
      exp_num = (n > 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : n[63:0];
      exp_den = (d > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
      exp_cnt = 16'(q_d.size());
      exp_err = (d == 64'h0);
      q_d.delete();
      q_w.delete();
   endfunction

   task automatic push(input logic [31:0] d, input logic [15:0] w, input logic fl, output logic closed);
      int n;
      n = 0;
      closed = 1'b0;
      in_valid = 1'b1; in_data = d; in_weight = w; flush = fl;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("in_ready_wait", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      q_d.push_back(d);
      q_w.push_back(w);
      if (q_d.size() == WINDOW || fl) begin
         close_model();
         closed = 1'b1;
      end
   endtask

   task automatic do_flush(output logic closed);
      closed = 1'b0;
      in_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      if (q_d.size() > 0) begin
         close_model();
         closed = 1'b1;
      end
   endtask

   // Called at the first negedge after the window-closing edge
   task automatic check_window(input int stall);
      int          n;
      int          s0;
      logic [31:0] held;
      s0 = start_cnt;
      n  = 0;
      check_eq("in_ready_busy", 64'(in_ready), 64'd0);
      if (exp_err) begin
         check_eq("err_no_start", 64'(div_start), 64'd0);
         check_eq("err_valid_now", 64'(out_valid), 64'd1);
      end else begin
         check_eq("start_at_t1", 64'(div_start), 64'd1);
         while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         check_eq("mean_valid", 64'(out_valid), 64'd1);
         check_eq("mean_latency", 64'(n), 64'd5);
      end
      check_eq("start_pulses", 64'(start_cnt - s0), exp_err ? 64'd0 : 64'd1);
      check_eq("mean", 64'(out_mean), exp_err ? 64'd0 : 64'(dv_quot));
      check_eq("err", 64'(out_err), 64'(exp_err));
      check_eq("count", 64'(out_count), 64'(exp_cnt));
      check_eq("div_num", div_num, exp_num);
      check_eq("div_den", 64'(div_den), 64'(exp_den));
      held = out_mean;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; in_data = $urandom; in_weight = 16'($urandom);
         @(negedge clk);
         check_eq("stall_valid", 64'(out_valid), 64'd1);
         check_eq("stall_mean", 64'(out_mean), 64'(held));
         check_eq("stall_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("valid_drop", 64'(out_valid), 64'd0);
      check_eq("ready_back", 64'(in_ready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check_eq({tag, "_start"}, 64'(div_start), 64'd0);
      check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
      check_eq({tag, "_num"}, div_num, 64'd0);
      check_eq({tag, "_den"}, 64'(div_den), 64'd0);
      check_eq({tag, "_mean"}, 64'(out_mean), 64'd0);
      check_eq({tag, "_err"}, 64'(out_err), 64'd0);
      check_eq({tag, "_count"}, 64'(out_count), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic closed;
      int   seen;
      rstn = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_weight = 16'h0; flush = 1'b0;
      div_done = 1'b0; div_result = 32'h0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rstn = 1'b1;

      // Four equal-weight samples close the window by count
      for (int i = 1; i <= 4; i++) push(32'(i * 100), 16'h8000, 1'b0, closed);
      check_window(0);
      check_eq("tp1_num", div_num, 64'd32768000);
      check_eq("tp1_den", 64'(div_den), 64'h20000);

      // Flush on the second accept; the stale done from the previous divide must be ignored
      push(32'd7, 16'hFFFF, 1'b0, closed);
      push(32'd7, 16'hFFFF, 1'b1, closed);
      check_window(0);
      check_eq("tp2_den", 64'(div_den), 64'h1FFFE);

      // All-zero weights: no divide, error result; then a long output stall
      for (int i = 0; i < 3; i++) push(32'($urandom), 16'h0000, 1'b0, closed);
      do_flush(closed);
      check_window(10);

      // Reset during WAIT, then a late done and an empty flush must change nothing
      for (int i = 0; i < 4; i++) push($urandom, 16'($urandom), 1'b0, closed);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rstn = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      check_eq("late_done_ignored", 64'(seen), 64'd0);
      do_flush(closed);
      check_eq("empty_flush_ready", 64'(in_ready), 64'd1);
      check_eq("empty_flush_valid", 64'(out_valid), 64'd0);
      check_eq("empty_flush_start", 64'(div_start), 64'd0);
      for (int i = 0; i < 4; i++) push($urandom, 16'($urandom), 1'b0, closed);
      check_window(1);

      // Random windows: sizes, weights, flush placement, gaps and stalls
      for (int w = 0; w < 15; w++) begin
         int   n;
         logic zero;
         logic fl_last;
         closed  = 1'b0;
         n       = $urandom_range(1, WINDOW);
         zero    = ($urandom_range(0, 4) == 0);
         fl_last = ($urandom_range(0, 1) == 1);
         for (int i = 0; i < n && !closed; i++) begin
            if ($urandom_range(0, 2) == 0) @(negedge clk);
            push($urandom, zero ? 16'h0000 : 16'($urandom), (i == n - 1) && fl_last, closed);
         end
         if (!closed) do_flush(closed);
         check_window($urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
